// File: rtl/gate_pkg.sv
// gate_pkg: shared definitions for the pipelined bitwise gate unit.
//   op_e       - 3-bit operation encoding carried on the op port.
//   gate_word_t - widest operand the gate function handles; callers
//                zero-extend narrower operands and keep the low bits.
//   gate_apply - combinational bitwise evaluation of op(a, b).
package gate_pkg;

    localparam int GATE_MAX_W = 64;

    typedef logic [GATE_MAX_W-1:0] gate_word_t;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_XNOR = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_NOT  = 3'd6,
        OP_BUF  = 3'd7
    } op_e;

    // Complementing ops also set the zero-extended upper bits; callers
    // only look at their own width, so that is harmless.
    function automatic gate_word_t gate_apply(input op_e op, input gate_word_t a,
                                              input gate_word_t b);
        gate_word_t r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_NOT:  r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_pipe_slice.sv
// gate_pipe_slice: one valid/ready register slice.
//   in_valid/in_ready/in_data    - upstream side
//   out_valid/out_ready/out_data - downstream side (registered)
// Ready is combinational from downstream (no skid buffer), so a full
// slice can drain and refill in the same cycle.
module gate_pipe_slice #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign in_ready = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) data_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/gate_pipe.sv
// gate_pipe: pipelined WIDTH-bit bitwise logic unit with accumulate mode.
//   clk, rst_n          - clock, async active-low reset
//   in_valid/in_ready   - input handshake
//   op, acc_en, in_last - operation, accumulate beat, end of packet
//   x, y                - operands (y unused for NOT/BUF and accumulate)
//   out_valid/out_ready - output handshake
//   z, z_par, out_last  - result, its parity, packet end flag
// The result is formed at acceptance and travels through STAGES slices
// as {last, parity, z}.
module gate_pipe
    import gate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic             in_last,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             z_par,
    output logic             out_last
);

    localparam int PW = WIDTH + 2;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             seeded_q, seeded_d;
    gate_word_t       opa, opb, res_w, unused_res;
    logic [WIDTH-1:0] res;
    logic             accept;

    logic [STAGES:0]         vld_pipe, rdy_pipe;
    logic [STAGES:0][PW-1:0] dat_pipe;

    assign accept = in_valid && in_ready;

    // Accumulate beats fold x into the running value; plain beats use x, y.
    always_comb begin
        opa = '0;
        opb = '0;
        if (acc_en) begin
            opa[WIDTH-1:0] = acc_q;
            opb[WIDTH-1:0] = x;
        end else begin
            opa[WIDTH-1:0] = x;
            opb[WIDTH-1:0] = y;
        end
    end

    assign res_w      = gate_apply(op_e'(op), opa, opb);
    assign unused_res = res_w;

    // First beat of a packet seeds the accumulator with x unchanged.
    assign res = (acc_en && !seeded_q) ? x : res_w[WIDTH-1:0];

    always_comb begin
        acc_d    = acc_q;
        seeded_d = seeded_q;
        if (accept && acc_en) begin
            if (in_last) begin
                acc_d    = '0;
                seeded_d = 1'b0;
            end else begin
                acc_d    = res;
                seeded_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            seeded_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            seeded_q <= seeded_d;
        end
    end

    assign vld_pipe[0]      = in_valid;
    assign dat_pipe[0]      = {in_last && acc_en, ^res, res};
    assign rdy_pipe[STAGES] = out_ready;
    assign in_ready         = rdy_pipe[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        gate_pipe_slice #(.W(PW)) u_slice (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (vld_pipe[i]),
            .in_ready  (rdy_pipe[i]),
            .in_data   (dat_pipe[i]),
            .out_valid (vld_pipe[i+1]),
            .out_ready (rdy_pipe[i+1]),
            .out_data  (dat_pipe[i+1])
        );
    end

    assign out_valid                = vld_pipe[STAGES];
    assign {out_last, z_par, z}     = dat_pipe[STAGES];

endmodule
